// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with a single outstanding memory request,
// a 2-entry {pc, instruction} buffer toward decode, and redirect handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t state, state_next;
    logic [31:0] pc, pc_next;
    logic [1:0] count, count_next, slot;
    logic [31:0] e1_pc, e1_data;
    logic ack, pop, push;
    assign ack = imem_ack & imem_req;
    assign pop = inst_valid & inst_ready;
    assign push = ack & (state == FETCH) & ~redirect;
    assign slot = count - {1'b0, pop};
    assign inst_valid = count != 2'd0;
    always_comb begin
        state_next = state;
        pc_next = pc;
        count_next = count + {1'b0, push} - {1'b0, pop};
        if (redirect) begin
            pc_next = {redirect_pc[31:2], 2'b00};
            count_next = 2'd0;
            state_next = (imem_req && !ack) ? DISCARD : FETCH;
        end else if (state == FETCH) begin
            pc_next = push ? pc + 32'd4 : pc;
            state_next = (push && count_next > 2'd1) ? HOLD : FETCH;
        end else if (state == HOLD) begin
            state_next = (count_next <= 2'd1) ? FETCH : HOLD;
        end else begin
            state_next = ack ? FETCH : DISCARD;
        end
    end
    // The head register keeps its last value once the buffer empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc <= RESET_PC;
            count <= 2'd0;
            imem_req <= 1'b0;
            imem_addr <= RESET_PC;
            inst_pc <= 32'd0;
            inst_data <= 32'd0;
            e1_pc <= 32'd0;
            e1_data <= 32'd0;
        end else begin
            state <= state_next;
            pc <= pc_next;
            count <= count_next;
            imem_req <= state_next != HOLD;
            imem_addr <= (state_next == DISCARD) ? imem_addr : pc_next;
            if (push && slot == 2'd0) begin
                inst_pc <= imem_addr;
                inst_data <= imem_rdata;
            end else if (pop && count == 2'd2 && !redirect) begin
                inst_pc <= e1_pc;
                inst_data <= e1_data;
            end
            if (push && slot == 2'd1) begin
                e1_pc <= imem_addr;
                e1_data <= imem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus against a queue-based
// reference model of the fetch buffer and request protocol.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic inst_ready = 1'b0;
    logic imem_req, inst_valid, w_req, w_valid;
    logic [31:0] imem_addr, inst_data, inst_pc, w_addr, w_data, w_pc;
    int total = 0;
    int bad = 0;
    bit en = 0;

    logic [63:0] m_q[$];
    bit m_req, m_stale;
    logic [31:0] m_addr, m_pc, m_hpc, m_hdata;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .redirect(1'b0), .redirect_pc(32'd0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_valid(w_valid), .inst_ready(inst_ready),
        .inst_data(w_data), .inst_pc(w_pc)
    );

    always #10 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_req = 0;
        m_stale = 0;
        m_addr = 32'd0;
        m_pc = 32'd0;
        m_hpc = 32'd0;
        m_hdata = 32'd0;
    endtask

    // Next-cycle expectation from the inputs about to be sampled.
    task automatic model_step();
        bit ack, pop;
        ack = imem_ack && m_req;
        pop = m_q.size() != 0 && inst_ready;
        if (pop) void'(m_q.pop_front());
        if (redirect) begin
            m_q.delete();
            m_pc = redirect_pc & ~32'd3;
            if (m_req && !ack) m_stale = 1;
            else begin
                m_stale = 0;
                m_req = 1;
                m_addr = m_pc;
            end
        end else if (ack && m_stale) begin
            m_stale = 0;
            m_addr = m_pc;
        end else if (ack) begin
            m_q.push_back({m_addr, imem_rdata});
            m_pc = m_pc + 32'd4;
            m_req = m_q.size() <= 1;
            m_addr = m_pc;
        end else if (!m_req && m_q.size() <= 1) begin
            m_req = 1;
            m_addr = m_pc;
        end
        if (m_q.size() != 0) {m_hpc, m_hdata} = m_q[0];
    endtask

    task automatic drive(input logic a, input logic r, input logic rd, input logic [31:0] rp);
        #1;
        imem_ack = a;
        inst_ready = r;
        redirect = rd;
        redirect_pc = rp;
        imem_rdata = $urandom;
        model_step();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_data", inst_data, 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("req", {31'd0, imem_req}, {31'd0, m_req});
            if (m_req) chk("addr", imem_addr, m_addr);
            chk("valid", {31'd0, inst_valid}, {31'd0, m_q.size() != 0});
            chk("inst_pc", inst_pc, m_hpc);
            chk("inst_data", inst_data, m_hdata);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        chk("reset_valid", {31'd0, inst_valid}, 32'd0);
        chk("reset_addr", imem_addr, 32'd0);
        chk("reset_wrap_addr", w_addr, 32'hFFFF_FFF8);
        #1 rst_n = 1'b1;
        en = 1;
        for (int i = 1; i <= 5; i++) begin
            drive(1, 1, 0, 0);
            if (i >= 2) begin
                chk("seq_pc", inst_pc, 32'((i - 2) * 4));
                chk("wrap_pc", w_pc, 32'hFFFF_FFF8 + 32'((i - 2) * 4));
            end else chk("seq_first_valid", {31'd0, inst_valid}, 32'd0);
        end
        reset_pulse();
        repeat (6) drive(1, 0, 0, 0);
        chk("bp_req", {31'd0, imem_req}, 32'd0);
        chk("bp_valid", {31'd0, inst_valid}, 32'd1);
        chk("bp_head", inst_pc, 32'd0);
        drive(0, 1, 0, 0);
        chk("drain_pc", inst_pc, 32'd4);
        drive(0, 1, 0, 0);
        chk("drain_empty", {31'd0, inst_valid}, 32'd0);
        chk("drain_hold", inst_pc, 32'd4);
        drive(0, 1, 1, 32'h100);
        chk("disc_addr", imem_addr, 32'd8);
        repeat (2) drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        chk("disc_drop", {31'd0, inst_valid}, 32'd0);
        chk("disc_newaddr", imem_addr, 32'h100);
        drive(1, 1, 0, 0);
        chk("redir_pc", inst_pc, 32'h100);
        drive(1, 1, 1, 32'h43);
        chk("coinc_empty", {31'd0, inst_valid}, 32'd0);
        chk("coinc_addr", imem_addr, 32'h40);
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, $urandom);
            if (i == 1500) reset_pulse();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
